// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC owner with EX redirect, load-use hold, halt/resume FSM and statistics counters
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic             go,
    input  logic             load_use_stall,
    input  logic             redirect_valid,
    input  logic             redirect_is_branch,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      pc,
    output logic             if_valid,
    output logic             stall_pc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             halted,
    output logic [CNT_W-1:0] cnt_cycles,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_jump,
    output logic [CNT_W-1:0] cnt_stall
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t      state, state_nx;
    logic [31:0] pc_nx;
    logic        run, do_redirect, do_stall;
    assign halted = state == HALTED;
    always_comb begin
        run         = state == RUN;
        do_redirect = run && !halt && redirect_valid;
        do_stall    = run && !halt && !redirect_valid && load_use_stall;
        state_nx    = run ? (halt ? HALTED : RUN) : (go ? RUN : HALTED);
        pc_nx       = do_redirect ? redirect_pc :
                      (!run || halt || do_stall) ? pc : pc + 32'd1;
        if_valid    = !rst && run;
        stall_pc    = !rst && (!run || do_stall);
        flush_ifid  = !rst && do_redirect;
        flush_idex  = !rst && do_redirect;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            cnt_cycles <= '0;
            cnt_branch <= '0;
            cnt_jump   <= '0;
            cnt_stall  <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (run)
                cnt_cycles <= cnt_cycles + 1'b1;
            if (do_redirect && redirect_is_branch)
                cnt_branch <= cnt_branch + 1'b1;
            if (do_redirect && !redirect_is_branch)
                cnt_jump <= cnt_jump + 1'b1;
            if (do_stall)
                cnt_stall <= cnt_stall + 1'b1;
        end
    end
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed self-checking bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;
    logic        clk = 0;
    logic        rst, halt, go, load_use_stall, redirect_valid, redirect_is_branch;
    logic [31:0] redirect_pc, pc;
    logic        if_valid, stall_pc, flush_ifid, flush_idex, halted;
    logic [31:0] cnt_cycles, cnt_branch, cnt_jump, cnt_stall;
    int          checks = 0, errors = 0;

    pc_redirect_ctrl dut (
        .clk(clk), .rst(rst), .halt(halt), .go(go), .load_use_stall(load_use_stall),
        .redirect_valid(redirect_valid), .redirect_is_branch(redirect_is_branch),
        .redirect_pc(redirect_pc), .pc(pc), .if_valid(if_valid), .stall_pc(stall_pc),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .halted(halted),
        .cnt_cycles(cnt_cycles), .cnt_branch(cnt_branch), .cnt_jump(cnt_jump),
        .cnt_stall(cnt_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic comb(input string tag, input logic iv, input logic sp, input logic fl);
        @(negedge clk);
        check({tag, "_if_valid"}, {31'd0, if_valid}, {31'd0, iv});
        check({tag, "_stall_pc"}, {31'd0, stall_pc}, {31'd0, sp});
        check({tag, "_flush_ifid"}, {31'd0, flush_ifid}, {31'd0, fl});
        check({tag, "_flush_idex"}, {31'd0, flush_idex}, {31'd0, fl});
    endtask

    task automatic counters(input string tag, input int cy, input int br, input int jp, input int st);
        check({tag, "_cnt_cycles"}, cnt_cycles, cy);
        check({tag, "_cnt_branch"}, cnt_branch, br);
        check({tag, "_cnt_jump"}, cnt_jump, jp);
        check({tag, "_cnt_stall"}, cnt_stall, st);
    endtask

    initial begin
        rst = 1; halt = 0; go = 0; load_use_stall = 0;
        redirect_valid = 0; redirect_is_branch = 0; redirect_pc = 0;
        tick();
        comb("reset", 0, 0, 0);
        tick();
        check("reset_pc", pc, 0);
        check("reset_halted", {31'd0, halted}, 0);
        counters("reset", 0, 0, 0, 0);
        rst = 0;
        for (int i = 1; i <= 4; i++) begin
            comb("free", 1, 0, 0);
            tick();
            check("free_pc", pc, i);
        end
        counters("free", 4, 0, 0, 0);
        tick();
        check("pc5", pc, 5);
        redirect_valid = 1; redirect_is_branch = 1; redirect_pc = 32'h20;
        comb("branch", 1, 0, 1);
        tick();
        redirect_valid = 0;
        check("branch_pc", pc, 32'h20);
        tick();
        check("branch_pc_next", pc, 32'h21);
        check("branch_cnt", cnt_branch, 1);
        redirect_valid = 1; redirect_is_branch = 0; redirect_pc = 32'h40; load_use_stall = 1;
        comb("redir_stall", 1, 0, 1);
        tick();
        check("jump_pc", pc, 32'h40);
        counters("jump", 8, 1, 1, 0);
        redirect_pc = 32'd9;
        comb("jump2", 1, 0, 1);
        tick();
        redirect_valid = 0;
        check("jump2_pc", pc, 9);
        for (int i = 0; i < 3; i++) begin
            comb("stall", 1, 1, 0);
            tick();
            check("stall_pc_hold", pc, 9);
        end
        load_use_stall = 0;
        check("stall_cnt", cnt_stall, 3);
        tick();
        check("after_stall_pc", pc, 10);
        tick();
        tick();
        check("pre_halt_pc", pc, 12);
        halt = 1;
        comb("halt", 1, 0, 0);
        tick();
        halt = 0;
        check("halt_halted", {31'd0, halted}, 1);
        check("halt_pc", pc, 12);
        counters("halt", 16, 1, 2, 3);
        redirect_valid = 1; redirect_is_branch = 1; redirect_pc = 32'h77; load_use_stall = 1;
        comb("halted_redir", 0, 1, 0);
        tick();
        redirect_valid = 0; load_use_stall = 0;
        check("halted_pc", pc, 12);
        for (int i = 0; i < 3; i++) begin
            comb("halted", 0, 1, 0);
            tick();
        end
        counters("halted", 16, 1, 2, 3);
        check("halted_hold", {31'd0, halted}, 1);
        go = 1;
        comb("go", 0, 1, 0);
        tick();
        go = 0;
        check("go_halted", {31'd0, halted}, 0);
        check("go_pc", pc, 12);
        comb("resume", 1, 0, 0);
        tick();
        check("resume_pc", pc, 13);
        check("resume_cycles", cnt_cycles, 17);
        redirect_valid = 1; redirect_is_branch = 0; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 0;
        check("wrap_target", pc, 32'hFFFF_FFFF);
        tick();
        check("wrap_pc", pc, 0);
        halt = 1;
        tick();
        halt = 0;
        check("halt2", {31'd0, halted}, 1);
        rst = 1; redirect_valid = 1;
        comb("rst_halted", 0, 0, 0);
        tick();
        rst = 0; redirect_valid = 0;
        check("rst_pc", pc, 0);
        check("rst_halted", {31'd0, halted}, 0);
        counters("rst", 0, 0, 0, 0);
        tick();
        check("post_rst_pc", pc, 1);
        check("post_rst_cycles", cnt_cycles, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
